// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: four-requester byte stream bundle (valid/ready, packed data, last)
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave (input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter of four byte streams onto one UART 8N1 line
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave req,
  input  logic [3:0]       enable_mask,
  output logic             tx,
  output logic             busy,
  output logic             grant_valid,
  output logic [1:0]       grant_id
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [15:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic last_q, lock, found, baud_done, release_lock, xfer;
  logic [1:0] rr_ptr, sel, idx;
  logic [3:0] elig;
  always_comb begin
    elig = lock ? (4'(req.req_valid[grant_id] & enable_mask[grant_id]) << grant_id) : req.req_valid & enable_mask;
    sel = rr_ptr;
    idx = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    baud_done = baud == 16'(CLKS_PER_BIT - 1);
    release_lock = lock && !enable_mask[grant_id];
    xfer = state == IDLE && found && rst_n;
    req.req_ready = xfer ? 4'b1 << sel : 4'b0;
    state_n = state == IDLE  ? (xfer ? START : IDLE) :
              state == START ? (baud_done ? DATA : START) :
              state == DATA  ? (baud_done && bit_cnt == 3'd7 ? STOP : DATA) :
                               (baud_done ? IDLE : STOP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      baud <= 16'd0;
      bit_cnt <= 3'd0;
      shreg <= 8'd0;
      last_q <= 1'b0;
      lock <= 1'b0;
      rr_ptr <= 2'd0;
      grant_id <= 2'd0;
      grant_valid <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      baud <= (state == IDLE || baud_done) ? 16'd0 : baud + 16'd1;
      if (xfer) begin
        shreg <= req.req_data[8*sel +: 8];
        last_q <= req.req_last[sel];
        grant_id <= sel;
        grant_valid <= 1'b1;
        lock <= 1'b1;
        tx <= 1'b0;
      end else if (state == IDLE && release_lock) begin
        lock <= 1'b0;
        grant_valid <= 1'b0;
        rr_ptr <= grant_id + 2'd1;
      end
      if (baud_done && state == START) begin
        tx <= shreg[0];
        shreg <= shreg >> 1;
      end
      // shreg[0] always holds the next bit to present; after bit 7 the stop bit follows
      if (baud_done && state == DATA) begin
        bit_cnt <= bit_cnt + 3'd1;
        tx <= bit_cnt == 3'd7 ? 1'b1 : shreg[0];
        shreg <= shreg >> 1;
      end
      if (baud_done && state == STOP && last_q) begin
        lock <= 1'b0;
        grant_valid <= 1'b0;
        rr_ptr <= grant_id + 2'd1;
      end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one serial output line (TX0 class pin) between four byte-stream requesters. Each requester uses a valid/ready handshake. Arbitration is round-robin with packet locking, so a multi-byte message is never interleaved with another requester's bytes. The winning byte is serialized as UART 8N1, LSB first. The block sits between the demo producers (counter, bus monitor, gauge reporter, loopback) and the top-level TX pin.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200); legal range 2..65535

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  4  per-requester byte valid
req_data  input  32  packed bytes; requester i on bits [8i+7:8i]
req_last  input  4  per-requester flag: this byte ends the packet
req_ready  output  4  per-requester accept strobe; at most one bit high
enable_mask  input  4  per-requester enable; a disabled requester is never newly granted
tx  output  1  serial line, idle high
busy  output  1  high while a frame is on the line
grant_valid  output  1  high while a packet owns the line
grant_id  output  2  index of the owning requester

Behaviour:
- Reset (async, rst_n low):
  - Registered outputs: tx=1, busy=0, grant_valid=0, grant_id=0.
  - req_ready=0. Lock cleared; rr_ptr=0; state=IDLE.
  - Assertion mid-frame aborts the frame immediately. No partial recovery is attempted.
- States: IDLE, START, DATA, STOP. busy = (state != IDLE), registered.
- IDLE, eligibility:
  - Lock held: eligible set = {grant_id} if req_valid[grant_id] and enable_mask[grant_id].
  - Lock not held: eligible set = req_valid & enable_mask.
- IDLE, selection:
  - Pick the first eligible index scanning rr_ptr, rr_ptr+1, ... mod 4.
  - req_ready[sel]=1 combinationally in the same cycle. No req_ready bit is high outside IDLE.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both high.
  - On transfer: latch the byte and the last flag; set grant_id=i and grant_valid=1; set lock=1; go to START.
- Frame timing (transfer at edge T):
  - tx=0 for CLKS_PER_BIT cycles starting the cycle after T.
  - Then data bits 0..7, each CLKS_PER_BIT cycles.
  - Then stop bit (tx=1) for CLKS_PER_BIT cycles, then IDLE.
  - Minimum spacing between consecutive transfers is 10*CLKS_PER_BIT+1 cycles.
- End of STOP when the latched last=1:
  - lock=0, grant_valid=0.
  - rr_ptr=(grant_id+1) mod 4, wrapping 3->0.
  - grant_id retains its value.
- End of STOP when the latched last=0: lock is kept; only grant_id can be served next.
- Locked requester stalls (valid low): line idles high indefinitely. No timeout, no other grant; grant_valid stays 1.
- enable_mask[grant_id] dropped while locked:
  - The byte currently on the line completes.
  - At the next IDLE the lock is released, grant_valid=0, rr_ptr=(grant_id+1) mod 4.
  - Normal arbitration resumes in the following cycle.
- enable_mask changes affect only the eligibility of new grants.
- Simultaneous requests: exactly one is granted per IDLE evaluation, chosen strictly by rr_ptr order.
- Data changing while valid is high and no transfer has occurred is legal. The value captured is the one present at the transfer edge.
- Bit counter: 3 bits. Baud counter: 16 bits, wraps to 0 at CLKS_PER_BIT-1.

Test Plan:
- Single byte, CLKS_PER_BIT=4: req0 sends 0x55 with last=1 -> req_ready[0] high exactly 1 cycle; tx pattern 0,1,0,1,0,1,0,1,0,1, each 4 cycles; busy high 40 cycles; afterwards grant_valid=0 and rr_ptr=1.
- All four single-byte requesters valid continuously -> grant order 0,1,2,3,0; transfers spaced exactly 41 cycles apart with CLKS_PER_BIT=4.
- Lock: req1 sends a 3-byte packet (0xA1,0xA2,0xA3; last on the third) while req0 and req2 are valid -> three req1 frames back-to-back, then req2, then req0; grant_valid high across all three req1 frames.
- enable_mask=4'b1010, all valid -> only 1 and 3 are served, alternating; req_ready[0] and req_ready[2] are never high.
- Locked req2 deasserts valid for 100 cycles mid-packet -> tx=1, busy=0, grant_valid=1, no other req_ready bit high; req2 resumes and its packet completes.
- rst_n pulsed low during data bit 3 -> tx=1 and busy=0 in the same cycle; grant_valid=0; after release, simultaneous requests on 2 and 0 grant requester 0 first.
